// File: rtl/q3c_seq_ctrl_if.sv
// q3c sequencing controller bus: upstream x-sample handshake, state
// configuration load, counter/flag clear and the registered status outputs.
interface q3c_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             in_valid;
  logic             in_x;
  logic             in_ready;
  logic             load;
  logic [2:0]       load_state;
  logic             clear;
  logic [2:0]       state;
  logic             z;
  logic             out_valid;
  logic [CNT_W-1:0] hit_count;
  logic             err;

  // Controlling side: bit source plus configuration/host logic.
  modport master (
    output en, in_valid, in_x, load, load_state, clear,
    input  in_ready, state, z, out_valid, hit_count, err
  );

  // Controller side.
  modport slave (
    input  en, in_valid, in_x, load, load_state, clear,
    output in_ready, state, z, out_valid, hit_count, err
  );
endinterface

// File: rtl/q3c_seq_ctrl.sv
// q3c sequencing controller: owns the five-state q3c FSM, advances it on
// handshaken x samples, supports state loads, recovers from illegal codes
// and keeps a saturating count of z rising edges.
module q3c_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           resetn,
  q3c_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S000 = 3'b000,
    S001 = 3'b001,
    S010 = 3'b010,
    S011 = 3'b011,
    S100 = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic             z_reg, z_next;
  logic             out_valid_reg, out_valid_next;
  logic [CNT_W-1:0] hit_reg, hit_next;
  logic             err_reg, err_next;
  logic             in_ready;
  logic             accept;
  state_t           fsm_next;

  // z is a pure function of a state code; applied to the next state so the
  // registered z always matches the registered state.
  function automatic logic z_of(input state_t s);
    return (s == S011) || (s == S100);
  endfunction

  // Codes above 100 are not part of the machine.
  function automatic logic is_illegal(input logic [2:0] s);
    return s > 3'b100;
  endfunction

  // Handshake: no samples while disabled or while a load owns the register.
  assign in_ready = bus.en & ~bus.load;
  assign accept   = bus.in_valid & in_ready;

  // q3c next-state function for the current state and the offered x.
  always_comb begin
    fsm_next = S000;
    case (state_reg)
      S000:    fsm_next = bus.in_x ? S001 : S000;
      S001:    fsm_next = bus.in_x ? S100 : S001;
      S010:    fsm_next = bus.in_x ? S001 : S010;
      S011:    fsm_next = bus.in_x ? S010 : S001;
      S100:    fsm_next = bus.in_x ? S100 : S011;
      default: fsm_next = S000;
    endcase
  end

  // Per-edge priority: load, then illegal recovery, then accept; clear is
  // applied last so it overrides any increment or error set in this cycle.
  always_comb begin
    state_next     = state_reg;
    out_valid_next = 1'b0;
    hit_next       = hit_reg;
    err_next       = err_reg;

    if (bus.load) begin
      if (is_illegal(bus.load_state)) begin
        state_next = S000;
        err_next   = 1'b1;
      end else begin
        state_next = state_t'(bus.load_state);
      end
    end else if (is_illegal(state_reg)) begin
      state_next = S000;
      err_next   = 1'b1;
    end else if (accept) begin
      state_next     = fsm_next;
      out_valid_next = 1'b1;
      // Count only z 0->1 moves caused by a sample, holding at the top.
      if (!z_of(state_reg) && z_of(fsm_next) && (hit_reg != HIT_MAX)) begin
        hit_next = hit_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    if (bus.clear) begin
      hit_next = '0;
      err_next = 1'b0;
    end

    z_next = z_of(state_next);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S000;
      z_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
      hit_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      z_reg         <= z_next;
      out_valid_reg <= out_valid_next;
      hit_reg       <= hit_next;
      err_reg       <= err_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.state     = state_reg;
  assign bus.z         = z_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.hit_count = hit_reg;
  assign bus.err       = err_reg;

  // z must always agree with the registered state.
  a_z_consistent : assert property (@(posedge clk) disable iff (!resetn)
    z_reg == ((state_reg == S011) || (state_reg == S100)));

  // A load never produces an output pulse.
  a_load_no_pulse : assert property (@(posedge clk) disable iff (!resetn)
    bus.load |=> !out_valid_reg);

endmodule

// File: tb/tb_q3c_seq_ctrl.sv
// Directed bench for q3c_seq_ctrl: a CNT_W=8 instance for the main features
// and a CNT_W=2 instance for counter saturation.
module tb_q3c_seq_ctrl;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  q3c_seq_ctrl_if #(.CNT_W(8)) b8 ();
  q3c_seq_ctrl_if #(.CNT_W(2)) b2 ();

  q3c_seq_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .resetn(resetn), .bus(b8));
  q3c_seq_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .resetn(resetn), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the 8-bit instance at the falling edge,
  // then return just after the following rising edge.
  task automatic step(input logic rn, input logic e, input logic v, input logic x,
                      input logic ld, input logic [2:0] ls, input logic cl);
    @(negedge clk);
    resetn        = rn;
    b8.en         = e;
    b8.in_valid   = v;
    b8.in_x       = x;
    b8.load       = ld;
    b8.load_state = ls;
    b8.clear      = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.state !== 3'b000) begin n_fail++; $display("FAIL reset_state got=%b exp=000", b8.state); end
    n_tests++; if (b8.z !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", b8.z); end
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", b8.out_valid); end
    n_tests++; if (b8.hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_hit got=%0d exp=0", b8.hit_count); end
    n_tests++; if (b8.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", b8.err); end
    n_tests++; if (b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", b8.in_ready); end
    $display("[TB] reset: state=%b z=%b hit=%0d", b8.state, b8.z, b8.hit_count);
  endtask

  task automatic test_sequence();
    logic       xs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] es [5] = '{3'b001, 3'b100, 3'b011, 3'b010, 3'b001};
    logic       ez [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, xs[i], 1'b0, 3'b000, 1'b0);
      n_tests++; if (b8.state !== es[i]) begin n_fail++; $display("FAIL seq_state[%0d] got=%b exp=%b", i, b8.state, es[i]); end
      n_tests++; if (b8.z !== ez[i]) begin n_fail++; $display("FAIL seq_z[%0d] got=%b exp=%b", i, b8.z, ez[i]); end
      n_tests++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_out_valid[%0d] got=%b exp=1", i, b8.out_valid); end
      $display("[TB] seq x=%b state=%b z=%b ov=%b", xs[i], b8.state, b8.z, b8.out_valid);
    end
    n_tests++; if (b8.hit_count !== 8'd1) begin n_fail++; $display("FAIL seq_hit got=%0d exp=1", b8.hit_count); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_ov_drop got=%b exp=0", b8.out_valid); end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      n_tests++; if (b8.state !== 3'b000) begin n_fail++; $display("FAIL hold_state[%0d] got=%b exp=000", i, b8.state); end
      n_tests++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ov[%0d] got=%b exp=1", i, b8.out_valid); end
      $display("[TB] hold x=0 state=%b ov=%b", b8.state, b8.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      n_tests++; if (b8.state !== 3'b000) begin n_fail++; $display("FAIL idle_state[%0d] got=%b exp=000", i, b8.state); end
      n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ov[%0d] got=%b exp=0", i, b8.out_valid); end
      $display("[TB] idle state=%b ov=%b", b8.state, b8.out_valid);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    b8.en = 1'b1; b8.in_valid = 1'b0; b8.load = 1'b1; b8.load_state = 3'b100; b8.clear = 1'b0;
    #1;
    n_tests++; if (b8.in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready got=%b exp=0", b8.in_ready); end
    @(posedge clk); #1;
    n_tests++; if (b8.state !== 3'b100) begin n_fail++; $display("FAIL load_state got=%b exp=100", b8.state); end
    n_tests++; if (b8.z !== 1'b1) begin n_fail++; $display("FAIL load_z got=%b exp=1", b8.z); end
    n_tests++; if (b8.hit_count !== 8'd0) begin n_fail++; $display("FAIL load_hit got=%0d exp=0", b8.hit_count); end
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL load_ov got=%b exp=0", b8.out_valid); end
    $display("[TB] load 100 state=%b z=%b hit=%0d", b8.state, b8.z, b8.hit_count);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
    n_tests++; if (b8.state !== 3'b000) begin n_fail++; $display("FAIL illload_state got=%b exp=000", b8.state); end
    n_tests++; if (b8.err !== 1'b1) begin n_fail++; $display("FAIL illload_err got=%b exp=1", b8.err); end
    $display("[TB] load 110 state=%b err=%b", b8.state, b8.err);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    n_tests++; if (b8.err !== 1'b0) begin n_fail++; $display("FAIL clear_err got=%b exp=0", b8.err); end
    $display("[TB] clear err=%b", b8.err);
  endtask

  task automatic test_saturation();
    logic [1:0] eh [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       xs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        b2.en = 1'b1; b2.in_valid = 1'b1; b2.in_x = xs[k];
        @(posedge clk); #1;
      end
      n_tests++; if (b2.hit_count !== eh[r]) begin n_fail++; $display("FAIL sat_hit[%0d] got=%0d exp=%0d", r, b2.hit_count, eh[r]); end
      n_tests++; if (b2.state !== 3'b001) begin n_fail++; $display("FAIL sat_state[%0d] got=%b exp=001", r, b2.state); end
      $display("[TB] sat round %0d state=%b hit=%0d", r, b2.state, b2.hit_count);
    end
    @(negedge clk);
    b2.in_valid = 1'b0; b2.en = 1'b0;
  endtask

  task automatic test_simultaneous();
    // Load beats a valid sample; the sample is not consumed.
    @(negedge clk);
    b8.en = 1'b1; b8.in_valid = 1'b1; b8.in_x = 1'b1; b8.load = 1'b1; b8.load_state = 3'b011; b8.clear = 1'b0;
    #1;
    n_tests++; if (b8.in_ready !== 1'b0) begin n_fail++; $display("FAIL simload_in_ready got=%b exp=0", b8.in_ready); end
    @(posedge clk); #1;
    n_tests++; if (b8.state !== 3'b011) begin n_fail++; $display("FAIL simload_state got=%b exp=011", b8.state); end
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL simload_ov got=%b exp=0", b8.out_valid); end
    $display("[TB] load+valid state=%b ov=%b", b8.state, b8.out_valid);
    // en=0 freezes the machine even with a valid sample.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.state !== 3'b011) begin n_fail++; $display("FAIL en0_state got=%b exp=011", b8.state); end
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL en0_ov got=%b exp=0", b8.out_valid); end
    $display("[TB] en=0 state=%b ov=%b", b8.state, b8.out_valid);
    // Clear coincident with a z-rising accept leaves the count at zero.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    n_tests++; if (b8.state !== 3'b100) begin n_fail++; $display("FAIL clrhit_state got=%b exp=100", b8.state); end
    n_tests++; if (b8.hit_count !== 8'd0) begin n_fail++; $display("FAIL clrhit_hit got=%0d exp=0", b8.hit_count); end
    n_tests++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL clrhit_ov got=%b exp=1", b8.out_valid); end
    $display("[TB] clear+rise state=%b hit=%0d", b8.state, b8.hit_count);
    // Counting resumes normally afterwards: 100 -0-> 011 -0-> 001 -1-> 100.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.hit_count !== 8'd1) begin n_fail++; $display("FAIL recount_hit got=%0d exp=1", b8.hit_count); end
    $display("[TB] recount state=%b hit=%0d", b8.state, b8.hit_count);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.state !== 3'b011) begin n_fail++; $display("FAIL mid_pre_state got=%b exp=011", b8.state); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.state !== 3'b000) begin n_fail++; $display("FAIL mid_state got=%b exp=000", b8.state); end
    n_tests++; if (b8.z !== 1'b0) begin n_fail++; $display("FAIL mid_z got=%b exp=0", b8.z); end
    n_tests++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ov got=%b exp=0", b8.out_valid); end
    n_tests++; if (b8.hit_count !== 8'd0) begin n_fail++; $display("FAIL mid_hit got=%0d exp=0", b8.hit_count); end
    $display("[TB] reset mid state=%b hit=%0d", b8.state, b8.hit_count);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    n_tests++; if (b8.state !== 3'b001) begin n_fail++; $display("FAIL resume_state got=%b exp=001", b8.state); end
    n_tests++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL resume_ov got=%b exp=1", b8.out_valid); end
    $display("[TB] resume state=%b ov=%b", b8.state, b8.out_valid);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    b8.en = 1'b0; b8.in_valid = 1'b0; b8.in_x = 1'b0; b8.load = 1'b0; b8.load_state = 3'b000; b8.clear = 1'b0;
    b2.en = 1'b0; b2.in_valid = 1'b0; b2.in_x = 1'b0; b2.load = 1'b0; b2.load_state = 3'b000; b2.clear = 1'b0;
    test_reset();
    test_sequence();
    test_hold();
    test_load();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
